// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver states and the
// oversampling tick divider.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clock_hz, input int baud);
        return (clock_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// CPU-facing read port of the UART receiver: pop/clear strobes in, FIFO head
// and status out.
interface uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             re;
    logic             clr_err;
    logic [7:0]       rdata;
    logic             ready;
    logic [CNT_W-1:0] count;
    logic             overrun;
    logic             frame_err;

    modport master (
        output re, clr_err,
        input  rdata, ready, count, overrun, frame_err
    );

    modport slave (
        input  re, clr_err,
        output rdata, ready, count, overrun, frame_err
    );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO with an explicit occupancy count;
// a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [AW:0]      count_q;
    logic             pop_ok;
    logic             push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers are exactly AW bits wide, so wrap-around is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a byte FIFO that the CPU
// polls through a memory-mapped read port.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLOCK_HZ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_i,
    uart_rx_fifo_if.slave bus
);
    localparam int DIV   = calc_div(CLOCK_HZ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] MID_SAMPLE  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

    logic             sync1_q;
    logic             rxs_q;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    rx_state_e        state_q;
    logic [3:0]       scnt_q;
    logic [2:0]       bcnt_q;
    logic [7:0]       shift_q;
    logic             push_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Presetting to 1 keeps a reset release from looking like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            rxs_q   <= sync1_q;
        end
    end

    // Divider is held at 0 in IDLE so each frame's tick phase starts fresh.
    assign tick = (state_q != ST_IDLE) && (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (state_q == ST_IDLE || tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            scnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (bus.clr_err) begin
                frame_err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (!rxs_q) begin
                        state_q <= ST_START;
                        scnt_q  <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (scnt_q == MID_SAMPLE) begin
                            scnt_q <= '0;
                            bcnt_q <= '0;
                            state_q <= rxs_q ? ST_IDLE : ST_DATA;
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        scnt_q <= scnt_q + 1'b1;
                        if (scnt_q == LAST_SAMPLE) begin
                            shift_q <= {rxs_q, shift_q[7:1]};
                            if (bcnt_q == 3'd7) begin
                                state_q <= ST_STOP;
                            end else begin
                                bcnt_q <= bcnt_q + 1'b1;
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        scnt_q <= scnt_q + 1'b1;
                        if (scnt_q == LAST_SAMPLE) begin
                            if (rxs_q) begin
                                push_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_BREAK;
                            end
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxs_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A full FIFO only drops the byte when no pop frees a slot that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (push_q && fifo_full && !bus.re) begin
            overrun_q <= 1'b1;
        end else if (bus.clr_err) begin
            overrun_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .pop_i   (bus.re),
        .din_i   (shift_q),
        .dout_o  (bus.rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.ready     = !fifo_empty;
    assign bus.count     = fifo_count;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Memory-mapped UART receiver with a byte FIFO. It sits between the rx pin and the data-memory read path at the UART address. The data memory drives re when the CPU reads the UART word and returns rdata in the LSB. The block oversamples rx at 16x, frames 8N1 bytes and buffers them so the CPU can poll without losing characters at 115200 baud.

Parameters:
- CLOCK_HZ, 50_000_000, system clock frequency.
- BAUD, 115_200, line rate.
- FIFO_DEPTH, 8, number of byte entries; must be a power of 2, at least 2.
- OVERSAMPLE, 16, ticks per bit; fixed at 16, not user-tunable.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous reset, active-low; deasserted synchronously by the integrator.
- rx  in  1  asynchronous serial input; idles high.
- re  in  1  pop strobe; one byte popped per cycle re=1 while not empty.
- clr_err  in  1  one-cycle pulse; clears sticky error flags.
- rdata  out  8  head-of-FIFO byte (first-word-fall-through); 0 when empty.
- ready  out  1  FIFO not empty.
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overrun  out  1  sticky: byte dropped because FIFO full.
- frame_err  out  1  sticky: stop bit sampled low.

Behaviour:
- Reset (reset=0): FIFO empty, rdata=0, ready=0, count=0, overrun=0, frame_err=0, FSM=IDLE. Both sync flops preset to 1.
- rx passes through a 2-flop synchronizer; all logic uses the synced value rxs. Pin-to-rxs latency is 2 cycles.
- Tick generator:
  - DIV = (CLOCK_HZ + 8*BAUD) / (16*BAUD), integer; 27 at the defaults.
  - tick pulses 1 cycle every DIV clocks.
  - The divider runs only outside IDLE and restarts at 0 on the IDLE->START transition.
- FSM states: IDLE, START, DATA, STOP, BREAK. A 4-bit sample counter scnt and a 3-bit bit counter bcnt advance on tick.
  - IDLE: rxs=0 -> START with scnt=0.
  - START: at tick with scnt==7 (mid start bit), rxs=0 -> DATA with scnt=0, bcnt=0. rxs=1 -> IDLE; this is a glitch, nothing recorded.
  - DATA: at tick with scnt==15, shift rxs into the shift register LSB-first. When bcnt==7 -> STOP, else bcnt++.
  - STOP: at tick with scnt==15:
    - rxs=1: push the byte -> IDLE.
    - rxs=0: set frame_err, discard the byte -> BREAK.
  - BREAK: wait for rxs=1 -> IDLE. Covers a held-low line so no spurious 0x00 bytes are generated.
- Push:
  - Occurs the cycle after the STOP decision.
  - If full and no pop in the same cycle: byte dropped, overrun=1.
  - If full and re pops in the same cycle: push accepted, no overrun, count unchanged.
- Pop:
  - re=1 and ready=1: head advances next cycle and count decrements.
  - re while empty is ignored; no underflow and no pointer movement.
- Simultaneous push and pop while non-empty: both occur, count unchanged.
  - On an empty FIFO with simultaneous push and pop, the pop is ignored and the push lands.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is kept as an explicit register so full is distinguishable from empty.
- rdata = mem[rd_ptr] when ready, else 0.
- Error flags:
  - clr_err clears both flags next cycle.
  - If clr_err coincides with a new error event, the set wins.
- Reset mid-frame aborts the frame and empties the FIFO. After release the FSM waits in IDLE for a falling edge; a partially received frame is not resumed.

Decomposition:
- Shared package uart_pkg:
  - state encoding enum (IDLE, START, DATA, STOP, BREAK);
  - function computing DIV from CLOCK_HZ/BAUD;
  - localparam OVERSAMPLE=16.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH). Ports clk, reset, push, pop, din, dout, count, full, empty. It is reusable for the TX side later.
- Synchronizer, divider and FSM live in uart_rx_fifo.

Test Plan:
All cases use CLOCK_HZ=1_843_200, BAUD=115_200 (DIV=1, 16 clocks per bit).
1. Send 0x55, 8N1 -> about 160 clocks after the start edge, ready=1, rdata=0x55, count=1, no flags. Pulse re -> next cycle ready=0, rdata=0.
2. Send 0x01..0x09 back-to-back with no reads -> count=8 and overrun=1 after the 9th byte. Popping 8 times yields 0x01..0x08 in order; 0x09 is lost.
3. With the FIFO full, pulse re exactly in the push cycle of a 9th byte 0xA5 -> overrun stays 0, count stays 8, last entry is 0xA5.
4. Low pulse of 5 clocks on idle rx -> FSM returns to IDLE, count=0, no flags.
5. Send 0x3C with the stop bit forced low, then hold rx low for 40 bits -> frame_err=1, count=0 throughout. Release rx high, then send 0x7E -> count=1, rdata=0x7E. Pulse clr_err -> frame_err=0.
6. Assert reset (0) during bit 4 of a frame with 3 bytes buffered -> immediately ready=0, count=0, all flags 0. After release a clean 0x42 is received correctly.
